axi4_lite_master_write_ctrl: RTL
================================

// Module: axi4_lite_master_write_ctrl
// PURPOSE
//   Parametrised AXI4-Lite write master, next generation of the core memory write path.
//   Accepts one write request over a valid/ready handshake and drives AW and W concurrently.
//   Byte strobes come from the requester.
//   Reports the B response, or a timeout if the slave stalls.
//   Sits between the core store/cache-writeback logic and the AXI interconnect.
// PARAMETERS
//   AXI_ADDR_WIDTH  64     address width
//   AXI_DATA_WIDTH  32     data width; must be 32 or 64; strobe width = AXI_DATA_WIDTH/8
//   AXI_PROT        3'b000 constant driven on AW_PROT
//   TIMEOUT_CYCLES  1024   max cycles waiting for B after AW+W accepted; 0 disables timeout
// PORTS
//   clk_i          in   1        clock
//   arst_i         in   1        async reset, active-high
//   req_valid_i    in   1        write request valid
//   req_ready_o    out  1        block idle, request accepted when req_valid_i & req_ready_o
//   req_addr_i     in   ADDR     write address
//   req_data_i     in   DATA     write data
//   req_strb_i     in   DATA/8   byte enables
//   rsp_valid_o    out  1        one-cycle pulse: transaction finished
//   rsp_resp_o     out  2        captured B_RESP (2'b00 on timeout)
//   rsp_fault_o    out  1        rsp_resp_o[1] or timeout; valid with rsp_valid_o
//   rsp_timeout_o  out  1        transaction ended by timeout; valid with rsp_valid_o
//   AW_READY       in   1        \
//   AW_VALID       out  1         |
//   AW_ADDR        out  ADDR      | AXI4-Lite write address channel
//   AW_PROT        out  3        /
//   W_READY        in   1        \
//   W_VALID        out  1         | AXI4-Lite write data channel
//   W_DATA         out  DATA      |
//   W_STRB         out  DATA/8   /
//   B_VALID        in   1        \
//   B_RESP         in   2         | AXI4-Lite write response channel
//   B_READY        out  1        /
// BEHAVIOUR
//   Reset (arst_i, async, active-high; clock clk_i):
//     - state=IDLE; AW_VALID, W_VALID, B_READY, rsp_* = 0.
//     - AW_ADDR, W_DATA, W_STRB = 0; timeout counter = 0.
//     - Reset mid-transaction drops all VALIDs immediately; no rsp pulse.
//   All outputs are registered, except:
//     - req_ready_o = (state==IDLE), a decode of the state flop.
//     - AW_PROT = AXI_PROT, constant.
//   States:
//     IDLE   on req handshake (edge N): latch addr/data/strb.
//            Set AW_VALID = W_VALID = 1 from N+1. Go to ADDR_DATA.
//     ADDR_DATA
//            - AW_VALID clears the cycle after AW_VALID & AW_READY.
//            - W_VALID clears the cycle after W_VALID & W_READY.
//            - The two channels are independent; either may finish first or both in the same cycle.
//            - Once both are accepted (same or later edge): set B_READY = 1, clear counter, go to RESP.
//            - AW_ADDR, W_DATA and W_STRB hold stable while their VALID is high.
//     RESP   - On B_VALID & B_READY: B_READY <= 0.
//              Pulse rsp_valid_o next cycle with rsp_resp_o = B_RESP; go to IDLE.
//            - Counter increments each cycle without B.
//            - If TIMEOUT_CYCLES != 0 and counter reaches TIMEOUT_CYCLES-1 without B:
//              pulse rsp_valid_o with rsp_timeout_o = 1, rsp_fault_o = 1; go to DRAIN.
//     DRAIN  B_READY stays 1. A late B is consumed silently, then B_READY <= 0 and go to IDLE.
//            req_ready_o = 0 while in DRAIN.
//   B_READY is never high before both AW and W have been accepted.
//   Minimum latency with a zero-wait slave:
//     - req handshake at edge 0; AW/W handshake at edge 1.
//     - B_READY high from cycle 2; B handshake at edge 2 if B_VALID is already high.
//     - rsp_valid_o high in cycle 3.
//   A new request can be accepted in the cycle rsp_valid_o pulses (state is already IDLE).
//   A B_VALID seen in IDLE or ADDR_DATA is ignored: B_READY = 0 there.
//   Counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
// TESTING
//   T1 zero-wait slave:
//      addr 0x1000, data 0xDEADBEEF, strb 4'hF.
//      -> AW and W accepted at edge 1; rsp_valid_o in cycle 3; resp 2'b00, fault 0.
//   T2 W_READY delayed 5 cycles, AW_READY immediate:
//      -> AW_VALID low from cycle 2; W_VALID held 6 cycles.
//      -> B_READY rises only after the W handshake; data and strb stable throughout.
//   T3 AW_READY delayed 3 cycles, strb 4'b0101:
//      -> W completes first; W_STRB = 4'b0101 on the bus; single rsp pulse.
//   T4 B_RESP = 2'b10 (SLVERR):
//      -> rsp_resp_o = 2'b10, rsp_fault_o = 1, rsp_timeout_o = 0.
//   T5 TIMEOUT_CYCLES = 8, B withheld 20 cycles:
//      -> rsp_timeout_o pulse 8 cycles after B_READY rises; req_ready_o = 0 until the late B is drained.
//   T6 arst_i asserted while in ADDR_DATA:
//      -> all VALIDs and B_READY low immediately; req_ready_o = 1 after release; a new write completes normally.

Source files
------------

// File: rtl/axi4_lite_master_write_ctrl.sv
// AXI4-Lite single-beat write master: takes one request, drives AW and W concurrently,
// then waits for B or times out. Every bus-facing output comes straight from a flop.
module axi4_lite_master_write_ctrl #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 32,   // 32 or 64
    parameter logic [2:0]  AXI_PROT       = 3'b000,
    parameter int unsigned TIMEOUT_CYCLES = 1024  // 0 disables the timeout
) (
    input  logic                          clk_i,
    input  logic                          arst_i,

    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]     req_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]   req_strb_i,

    output logic                          rsp_valid_o,
    output logic [1:0]                    rsp_resp_o,
    output logic                          rsp_fault_o,
    output logic                          rsp_timeout_o,

    input  logic                          AW_READY,
    output logic                          AW_VALID,
    output logic [AXI_ADDR_WIDTH-1:0]     AW_ADDR,
    output logic [2:0]                    AW_PROT,

    input  logic                          W_READY,
    output logic                          W_VALID,
    output logic [AXI_DATA_WIDTH-1:0]     W_DATA,
    output logic [AXI_DATA_WIDTH/8-1:0]   W_STRB,

    input  logic                          B_VALID,
    input  logic [1:0]                    B_RESP,
    output logic                          B_READY
);

    localparam int unsigned STRB_WIDTH   = AXI_DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH    = (TIMEOUT_CYCLES == 0) ? 1 :
                                           $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_LAST);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        StIdle,
        StAddrData,
        StResp,
        StDrain
    } state_e;

    state_e                      state_q, state_d;
    logic                        aw_valid_q, aw_valid_d;
    logic                        w_valid_q, w_valid_d;
    logic                        b_ready_q, b_ready_d;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
    logic [AXI_DATA_WIDTH-1:0]   w_data_q, w_data_d;
    logic [STRB_WIDTH-1:0]       w_strb_q, w_strb_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic [1:0]                  rsp_resp_q, rsp_resp_d;
    logic                        rsp_fault_q, rsp_fault_d;
    logic                        rsp_timeout_q, rsp_timeout_d;

    logic                        aw_accepted;
    logic                        w_accepted;
    logic                        b_handshake;

    // A channel counts as accepted if it handshakes now or already dropped its VALID.
    assign aw_accepted = !aw_valid_q || AW_READY;
    assign w_accepted  = !w_valid_q  || W_READY;
    assign b_handshake = B_VALID && b_ready_q;

    always_comb begin
        state_d       = state_q;
        aw_valid_d    = aw_valid_q;
        w_valid_d     = w_valid_q;
        b_ready_d     = b_ready_q;
        aw_addr_d     = aw_addr_q;
        w_data_d      = w_data_q;
        w_strb_d      = w_strb_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_resp_d    = rsp_resp_q;
        rsp_fault_d   = rsp_fault_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    aw_addr_d  = req_addr_i;
                    w_data_d   = req_data_i;
                    w_strb_d   = req_strb_i;
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                    state_d    = StAddrData;
                end
            end

            StAddrData: begin
                if (aw_valid_q && AW_READY) begin
                    aw_valid_d = 1'b0;
                end
                if (w_valid_q && W_READY) begin
                    w_valid_d = 1'b0;
                end
                if (aw_accepted && w_accepted) begin
                    b_ready_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = StResp;
                end
            end

            StResp: begin
                if (b_handshake) begin
                    b_ready_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = B_RESP;
                    rsp_fault_d   = B_RESP[1];
                    rsp_timeout_d = 1'b0;
                    state_d       = StIdle;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    // Keep B_READY up so a late response is swallowed in StDrain.
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = 2'b00;
                    rsp_fault_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = StDrain;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StDrain: begin
                if (b_handshake) begin
                    b_ready_d = 1'b0;
                    state_d   = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q       <= StIdle;
            aw_valid_q    <= 1'b0;
            w_valid_q     <= 1'b0;
            b_ready_q     <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_resp_q    <= 2'b00;
            rsp_fault_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            aw_valid_q    <= aw_valid_d;
            w_valid_q     <= w_valid_d;
            b_ready_q     <= b_ready_d;
            aw_addr_q     <= aw_addr_d;
            w_data_q      <= w_data_d;
            w_strb_q      <= w_strb_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_fault_q   <= rsp_fault_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ready_o   = (state_q == StIdle);
    assign AW_PROT       = AXI_PROT;

    assign AW_VALID      = aw_valid_q;
    assign AW_ADDR       = aw_addr_q;
    assign W_VALID       = w_valid_q;
    assign W_DATA        = w_data_q;
    assign W_STRB        = w_strb_q;
    assign B_READY       = b_ready_q;

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_resp_o    = rsp_resp_q;
    assign rsp_fault_o   = rsp_fault_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule
